chal_responder: RTL
===================

// Module: chal_responder
// PURPOSE
//  Host-side responder for the AES-128 challenge-response link. Parses "CHAL:<32 hex>\n" from a UART RX byte
//  stream, encrypts the 128-bit challenge with the shared key on an external aes_wrapper, and transmits
//  "RESP:<32 uppercase hex>\n" through uart_tx. Sits between uart_rx/uart_tx and aes_wrapper on the prover board.
// PARAMETERS
//  KEY             128'hA5C3_DEAD_BEEF_CAFE_1337_FACE_B00B_C0DE  shared secret, driven on aes_key
//  TIMEOUT_CYCLES  1_200_000                                     inter-byte timeout (100 ms @ 12 MHz), 24-bit counter
// PORTS
//  CLK             in   1    system clock (12 MHz)
//  rst_n           in   1    asynchronous active-low reset
//  rx_data         in   8    byte from uart_rx
//  rx_data_valid   in   1    one-cycle strobe, rx_data valid
//  tx_data         out  8    byte to uart_tx
//  tx_data_valid   out  1    one-cycle strobe to uart_tx
//  tx_busy         in   1    uart_tx busy
//  aes_start       out  1    one-cycle start pulse to aes_wrapper
//  aes_ready       in   1    aes_wrapper idle
//  aes_plaintext   out  128  parsed challenge, stable from aes_start until aes_valid
//  aes_key         out  128  constant KEY
//  aes_ciphertext  in   128  result, sampled when aes_valid=1
//  aes_valid       in   1    result valid
//  busy            out  1    1 in any state except HUNT
//  resp_done       out  1    one-cycle pulse after final '\n' of response leaves uart_tx (tx_busy falls)
//  err             out  1    one-cycle pulse on parse error or timeout
//  resp_count      out  16   responses sent, wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0 (aes_key = KEY), state HUNT, indices/timer 0. Reset mid-operation aborts at once;
//   uart_tx finishes any byte already in flight on its own.
//  FSM: HUNT -> HEX -> EOL -> AES_START -> AES_WAIT -> SEND -> HUNT.
//  HUNT: match "CHAL:" with pfx_idx 0..4. On a mismatched byte: pfx_idx=1 if byte=='C', else 0. No err.
//   After ':' go to HEX with hex_idx=0.
//  HEX: 32 chars, MSB nibble first, shifted into aes_plaintext. Accepts 0-9, A-F, a-f.
//   Any other byte -> err, HUNT (pfx_idx=1 if byte=='C', else 0).
//  EOL: '\r' ignored; '\n' -> AES_START; any other byte -> err, HUNT.
//  Timeout: in HUNT with pfx_idx>0, HEX or EOL, timer counts cycles without rx_data_valid.
//   Timer==TIMEOUT_CYCLES -> err, HUNT, pfx_idx=0. Timer clears on every accepted byte.
//  AES_START: aes_start=1 in the first cycle of this state with aes_ready=1, then AES_WAIT.
//   With aes_ready=0, wait with no timeout.
//  AES_WAIT: on aes_valid latch aes_ciphertext into cipher_q, send_idx=0, -> SEND.
//  SEND: 38 bytes "RESP:", cipher_q hex (nibble 31 first, 'A'-'F' uppercase), 0x0A.
//   Issue tx_data_valid only when tx_busy=0 and no byte outstanding; mark outstanding.
//   On tx_busy falling edge (registered tx_busy_prev=1, tx_busy=0), clear outstanding and send_idx++.
//   After byte 37 completes: resp_done pulse, resp_count++, -> HUNT.
//  Latency: '\n' accepted at cycle N -> aes_start at N+1 (aes_ready=1).
//   aes_valid at cycle M -> first tx_data_valid at M+1 (tx_busy=0).
//  rx_data_valid in AES_START/AES_WAIT/SEND: byte dropped, no err. A new challenge is hunted only after SEND.
//  Simultaneous rx byte and timeout expiry in the same cycle: the byte wins, timer clears.
//  err and resp_done never assert in the same cycle.
// STRUCTURE
//  Shared package chal_pkg holds:
//   - state encodings
//   - ASCII constants for the "CHAL:"/"RESP:" prefixes, LF and CR
//   - frame lengths (5, 32, 38)
//   - functions nibble_to_hex (uppercase) and hex_to_nibble (with valid flag)
//  Both ends of the link use this package. No sub-module; aes_wrapper is instantiated by the top,
//  next to uart_rx and uart_tx.
// TESTING (uart_tx behavioural model: busy for 10 cycles after valid; AES model: valid 20 cycles after start)
//  1 KEY=000102..0F; send "CHAL:00112233445566778899AABBCCDDEEFF\n"
//    -> aes_plaintext=0x00112233445566778899aabbccddeeff, exactly one aes_start;
//    model returns 69c4e0d86a7b0430d8cdb78070b4c55a;
//    TX stream "RESP:69C4E0D86A7B0430D8CDB78070B4C55A\n"; one resp_done; resp_count=1.
//  2 Same frame with lowercase hex and "\r\n" ending -> identical TX stream; resp_count=2.
//  3 "XCCHAL:0011G..." -> resync on 'C'; err pulse at 'G'; no aes_start.
//    A following valid frame is answered normally.
//  4 "CHAL:0011", then idle TIMEOUT_CYCLES -> single err pulse, busy=0; next valid frame answered.
//    A byte on the expiry cycle -> no err.
//  5 Hold aes_ready=0 for 100 cycles after '\n' -> aes_start is delayed, not lost.
//    "CHAL:..." bytes injected during SEND are dropped; TX stream is unchanged.
//  6 Assert rst_n=0 after the 10th response byte -> next cycle all outputs 0, state HUNT,
//    no further tx_data_valid; next frame after release answered.

Source files
------------

// File: rtl/chal_pkg.sv
// Shared definitions for both ends of the AES challenge-response link:
// FSM encodings, ASCII framing constants, frame lengths and hex helpers.
package chal_pkg;

  typedef enum logic [2:0] {
    ST_HUNT      = 3'd0,
    ST_HEX       = 3'd1,
    ST_EOL       = 3'd2,
    ST_AES_START = 3'd3,
    ST_AES_WAIT  = 3'd4,
    ST_SEND      = 3'd5
  } state_e;

  // ASCII constants
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_L     = 8'h4C;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  // Frame lengths and the last index of each field
  localparam int unsigned PFX_LEN  = 5;
  localparam int unsigned HEX_LEN  = 32;
  localparam int unsigned RESP_LEN = 38;
  localparam logic [2:0]  PFX_LAST  = 3'd4;
  localparam logic [4:0]  HEX_LAST  = 5'd31;
  localparam logic [5:0]  SEND_LAST = 6'd37;
  localparam logic [5:0]  SEND_HEX0 = 6'd5;   // first hex byte of the response

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_nib_t;

  // Character idx of "CHAL:"
  function automatic logic [7:0] chal_pfx_char(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = ASCII_C;
      3'd1:    c = ASCII_H;
      3'd2:    c = ASCII_A;
      3'd3:    c = ASCII_L;
      3'd4:    c = ASCII_COLON;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Character idx of "RESP:"
  function automatic logic [7:0] resp_pfx_char(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = ASCII_R;
      3'd1:    c = ASCII_E;
      3'd2:    c = ASCII_S;
      3'd3:    c = ASCII_P;
      3'd4:    c = ASCII_COLON;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Nibble to uppercase ASCII hex
  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = 8'h37 + {4'h0, n};
    end
    return c;
  endfunction

  // ASCII hex (either case) to nibble, valid flag low for non-hex bytes
  function automatic hex_nib_t hex_to_nibble(input logic [7:0] c);
    hex_nib_t r;
    r.valid = 1'b0;
    r.nib   = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.valid = 1'b1;
      r.nib   = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r.valid = 1'b1;
      r.nib   = c[3:0] + 4'd9;
    end else begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/chal_responder.sv
// Host-side responder: parses "CHAL:<32 hex>\n", runs the challenge through
// the external AES core and answers "RESP:<32 uppercase hex>\n" on uart_tx.
module chal_responder
  import chal_pkg::*;
#(
  parameter logic [127:0] KEY            = 128'hA5C3_DEAD_BEEF_CAFE_1337_FACE_B00B_C0DE,
  parameter logic [23:0]  TIMEOUT_CYCLES = 24'd1_200_000
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_data_valid,
  output logic [7:0]   tx_data,
  output logic         tx_data_valid,
  input  logic         tx_busy,
  output logic         aes_start,
  input  logic         aes_ready,
  output logic [127:0] aes_plaintext,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_ciphertext,
  input  logic         aes_valid,
  output logic         busy,
  output logic         resp_done,
  output logic         err,
  output logic [15:0]  resp_count
);

  state_e         state_q;
  logic [2:0]     pfx_idx_q;
  logic [4:0]     hex_idx_q;
  logic [5:0]     send_idx_q;
  logic [23:0]    timer_q;
  logic [127:0]   plain_q;
  logic [127:0]   cipher_q;
  logic           outstanding_q;
  logic           tx_busy_prev_q;
  logic [7:0]     tx_data_q;
  logic           tx_valid_q;
  logic           aes_start_q;
  logic           busy_q;
  logic           resp_done_q;
  logic           err_q;
  logic [15:0]    resp_count_q;

  hex_nib_t       hex_s;
  logic           timed_s;
  logic           timeout_s;
  logic           tx_fall_s;
  logic [5:0]     nib_pos_s;
  logic [7:0]     tx_byte_s;

  assign aes_key       = KEY;
  assign aes_plaintext = plain_q;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign aes_start     = aes_start_q;
  assign busy          = busy_q;
  assign resp_done     = resp_done_q;
  assign err           = err_q;
  assign resp_count    = resp_count_q;

  // Byte decode, inter-byte timeout detection and uart_tx completion edge
  always_comb begin
    hex_s   = hex_to_nibble(rx_data);
    timed_s = 1'b0;
    if (state_q == ST_HEX || state_q == ST_EOL) begin
      timed_s = 1'b1;
    end else if (state_q == ST_HUNT && pfx_idx_q != 3'd0) begin
      timed_s = 1'b1;
    end else begin
      timed_s = 1'b0;
    end
    timeout_s = timed_s && !rx_data_valid && (timer_q == TIMEOUT_CYCLES);
    tx_fall_s = tx_busy_prev_q && !tx_busy;
  end

  // Response byte for the current send index: prefix, nibble 31..0, LF
  always_comb begin
    nib_pos_s = 6'd0;
    tx_byte_s = ASCII_LF;
    if (send_idx_q < SEND_HEX0) begin
      tx_byte_s = resp_pfx_char(send_idx_q[2:0]);
    end else if (send_idx_q < SEND_LAST) begin
      nib_pos_s = 6'd36 - send_idx_q;
      tx_byte_s = nibble_to_hex(cipher_q[{nib_pos_s[4:0], 2'b00} +: 4]);
    end else begin
      tx_byte_s = ASCII_LF;
    end
  end

  // Main FSM with registered outputs; pulses default low each cycle
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_HUNT;
      pfx_idx_q      <= 3'd0;
      hex_idx_q      <= 5'd0;
      send_idx_q     <= 6'd0;
      timer_q        <= 24'd0;
      plain_q        <= 128'd0;
      cipher_q       <= 128'd0;
      outstanding_q  <= 1'b0;
      tx_busy_prev_q <= 1'b0;
      tx_data_q      <= 8'd0;
      tx_valid_q     <= 1'b0;
      aes_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      resp_done_q    <= 1'b0;
      err_q          <= 1'b0;
      resp_count_q   <= 16'd0;
    end else begin
      tx_valid_q     <= 1'b0;
      aes_start_q    <= 1'b0;
      resp_done_q    <= 1'b0;
      err_q          <= 1'b0;
      tx_busy_prev_q <= tx_busy;

      // A received byte always beats an expiring timer
      if (!timed_s || rx_data_valid || timeout_s) begin
        timer_q <= 24'd0;
      end else begin
        timer_q <= timer_q + 24'd1;
      end

      case (state_q)
        ST_HUNT: begin
          if (rx_data_valid) begin
            if (rx_data == chal_pfx_char(pfx_idx_q)) begin
              if (pfx_idx_q == PFX_LAST) begin
                state_q   <= ST_HEX;
                busy_q    <= 1'b1;
                hex_idx_q <= 5'd0;
                pfx_idx_q <= 3'd0;
              end else begin
                pfx_idx_q <= pfx_idx_q + 3'd1;
              end
            end else begin
              // A stray 'C' may itself start a new prefix
              pfx_idx_q <= (rx_data == ASCII_C) ? 3'd1 : 3'd0;
            end
          end else if (timeout_s) begin
            err_q     <= 1'b1;
            pfx_idx_q <= 3'd0;
          end else begin
            pfx_idx_q <= pfx_idx_q;
          end
        end

        ST_HEX: begin
          if (rx_data_valid) begin
            if (hex_s.valid) begin
              plain_q <= {plain_q[123:0], hex_s.nib};
              if (hex_idx_q == HEX_LAST) begin
                state_q <= ST_EOL;
              end else begin
                hex_idx_q <= hex_idx_q + 5'd1;
              end
            end else begin
              err_q     <= 1'b1;
              state_q   <= ST_HUNT;
              busy_q    <= 1'b0;
              pfx_idx_q <= (rx_data == ASCII_C) ? 3'd1 : 3'd0;
            end
          end else if (timeout_s) begin
            err_q     <= 1'b1;
            state_q   <= ST_HUNT;
            busy_q    <= 1'b0;
            pfx_idx_q <= 3'd0;
          end else begin
            hex_idx_q <= hex_idx_q;
          end
        end

        ST_EOL: begin
          if (rx_data_valid) begin
            if (rx_data == ASCII_LF) begin
              state_q <= ST_AES_START;
            end else if (rx_data == ASCII_CR) begin
              state_q <= ST_EOL;
            end else begin
              err_q     <= 1'b1;
              state_q   <= ST_HUNT;
              busy_q    <= 1'b0;
              pfx_idx_q <= 3'd0;
            end
          end else if (timeout_s) begin
            err_q     <= 1'b1;
            state_q   <= ST_HUNT;
            busy_q    <= 1'b0;
            pfx_idx_q <= 3'd0;
          end else begin
            state_q <= ST_EOL;
          end
        end

        ST_AES_START: begin
          // No timeout here: the AES core is trusted to become ready
          if (aes_ready) begin
            aes_start_q <= 1'b1;
            state_q     <= ST_AES_WAIT;
          end else begin
            state_q <= ST_AES_START;
          end
        end

        ST_AES_WAIT: begin
          if (aes_valid) begin
            cipher_q      <= aes_ciphertext;
            send_idx_q    <= 6'd0;
            outstanding_q <= 1'b0;
            state_q       <= ST_SEND;
          end else begin
            state_q <= ST_AES_WAIT;
          end
        end

        ST_SEND: begin
          if (outstanding_q) begin
            if (tx_fall_s) begin
              outstanding_q <= 1'b0;
              if (send_idx_q == SEND_LAST) begin
                resp_done_q  <= 1'b1;
                resp_count_q <= resp_count_q + 16'd1;
                state_q      <= ST_HUNT;
                busy_q       <= 1'b0;
                pfx_idx_q    <= 3'd0;
              end else begin
                send_idx_q <= send_idx_q + 6'd1;
              end
            end else begin
              outstanding_q <= 1'b1;
            end
          end else if (!tx_busy) begin
            tx_valid_q    <= 1'b1;
            tx_data_q     <= tx_byte_s;
            outstanding_q <= 1'b1;
          end else begin
            outstanding_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_HUNT;
          busy_q    <= 1'b0;
          pfx_idx_q <= 3'd0;
        end
      endcase
    end
  end

endmodule
